nn_mac_neuron: RTL and testbench

- Downstream consumer of the 32-bit input FIFO in the wishbone NN datapath.
- Pops packed {weight, activation} words, accumulates a signed fixed-point dot product over a programmable number of terms, adds a bias, then rescales and saturates.
- Presents one 16-bit neuron result on a valid/ready output port.
- Its pop strobe drives the FIFO read enable (FIFO write enable held low while popping); FIFO read data is combinational, so a popped word is consumed in the same cycle.

---
 rtl/nn_mac_neuron.sv | 187 ++++++++++++++++++
 tb/tb_nn_mac_neuron.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/nn_mac_neuron.sv
// nn_mac_neuron
//   Consumes packed {weight, activation} words from an upstream FIFO and
//   accumulates a signed fixed-point dot product over n_terms_i terms.
//   It then adds a bias, rescales by FRAC_BITS, saturates to 16 bits and
//   presents the result on a valid/ready port.
//
// Ports
//   clk          clock
//   rst          synchronous, active-high reset
//   start_i      one-cycle start request, sampled only in IDLE
//   n_terms_i    number of FIFO words to consume, latched on start
//   bias_i       signed Q8.8 bias, latched on start
//   in_empty_i   upstream FIFO empty
//   in_data_i    upstream word: [31:16] signed weight, [15:0] signed activation
//   in_pop_o     pop strobe (combinational); the FIFO read data is consumed
//                on the same edge
//   out_valid_o  result available
//   out_ready_i  downstream accepts the result
//   out_data_o   signed Q8.8 result, held until the next result
//   busy_o       high whenever the engine is not idle
//
// Build option
//   NN_MAC_RELU_EN : when defined, negative results are clamped to zero after
//                    saturation. Latency is the same in both builds.
module nn_mac_neuron #(
  parameter int ACC_W     = 40,
  parameter int FRAC_BITS = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_terms_i,
  input  logic [15:0]      bias_i,
  input  logic             in_empty_i,
  input  logic [31:0]      in_data_i,
  output logic             in_pop_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [15:0]      out_data_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        n_terms_q, n_terms_d;
  logic [15:0]             bias_q, bias_d;
  logic [15:0]             out_data_q, out_data_d;
  logic                    out_valid_q;
  logic                    busy_q;
  logic                    pop_s;

  logic signed [15:0]      weight_s;
  logic signed [15:0]      act_s;
  logic signed [31:0]      prod_s;
  logic signed [ACC_W-1:0] prod_ext_s;
  logic signed [ACC_W:0]   bias_ext_s;
  logic signed [ACC_W:0]   sum_s;
  logic signed [ACC_W:0]   shifted_s;
  logic [15:0]             sat_s;
  logic [15:0]             result_s;

  // Product, bias add, rescale, saturation and optional ReLU.
  always_comb begin
    weight_s   = in_data_i[31:16];
    act_s      = in_data_i[15:0];
    prod_s     = weight_s * act_s;
    prod_ext_s = {{(ACC_W-32){prod_s[31]}}, prod_s};
    // One guard bit so adding the bias cannot wrap before saturation.
    bias_ext_s = {{(ACC_W-15){bias_q[15]}}, bias_q};
    sum_s      = {acc_q[ACC_W-1], acc_q} + (bias_ext_s <<< FRAC_BITS);
    shifted_s  = sum_s >>> FRAC_BITS;
    // In range only when every bit above bit 15 equals the sign bit.
    if (!shifted_s[ACC_W] && (|shifted_s[ACC_W-1:15])) begin
      sat_s = 16'h7FFF;
    end else if (shifted_s[ACC_W] && !(&shifted_s[ACC_W-1:15])) begin
      sat_s = 16'h8000;
    end else begin
      sat_s = shifted_s[15:0];
    end
`ifdef NN_MAC_RELU_EN
    if (sat_s[15]) begin
      result_s = 16'h0000;
    end else begin
      result_s = sat_s;
    end
`else
    result_s = sat_s;
`endif
  end

  // Next-state and pop logic for the IDLE/ACCUM/FINISH/OUTPUT sequence.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    n_terms_d  = n_terms_q;
    bias_d     = bias_q;
    out_data_d = out_data_q;
    pop_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          n_terms_d = n_terms_i;
          bias_d    = bias_i;
          acc_d     = {ACC_W{1'b0}};
          cnt_d     = {CNT_W{1'b0}};
          if (n_terms_i == {CNT_W{1'b0}}) begin
            state_d = FINISH;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        // No pop while in reset, so a reset never drains a FIFO word.
        if (!in_empty_i && !rst) begin
          pop_s = 1'b1;
          acc_d = acc_q + prod_ext_s;
          cnt_d = cnt_q + CNT_ONE;
          if ((cnt_q + CNT_ONE) == n_terms_q) begin
            state_d = FINISH;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      FINISH: begin
        out_data_d = result_s;
        state_d    = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = OUTPUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      n_terms_q   <= {CNT_W{1'b0}};
      bias_q      <= 16'h0000;
      out_data_q  <= 16'h0000;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      n_terms_q   <= n_terms_d;
      bias_q      <= bias_d;
      out_data_q  <= out_data_d;
      out_valid_q <= (state_d == OUTPUT);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_pop_o    = pop_s;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_nn_mac_neuron.sv
module tb_nn_mac_neuron;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  n_terms = 8'd0;
  logic [15:0] bias = 16'h0000;
  logic        stall = 1'b0;
  logic        in_empty;
  logic [31:0] in_data;
  logic        in_pop;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        busy;

  // Simple FIFO model: the bench writes words, the DUT pops them.
  logic [31:0] fifo_mem [0:15];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign in_empty = (wr_ptr == rd_ptr) || stall;
  assign in_data  = fifo_mem[rd_ptr % 16];

  always @(posedge clk) begin
    if (in_pop) rd_ptr <= rd_ptr + 1;
  end

  nn_mac_neuron dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .n_terms_i  (n_terms),
    .bias_i     (bias),
    .in_empty_i (in_empty),
    .in_data_i  (in_data),
    .in_pop_o   (in_pop),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .busy_o     (busy)
  );

  typedef struct {
    logic [7:0]  n;
    logic [15:0] b;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [15:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [15:0] neg_exp(input logic [15:0] x);
`ifdef NN_MAC_RELU_EN
    return 16'h0000;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Loads the FIFO, starts one job and follows it until out_valid (at a negedge).
  task automatic run(input vec_t v, input int stall_after, input int stall_len,
                     output int lat, output int pops, output int first_pop,
                     output int last_pop, output int stall_pops);
    logic [31:0] w [3];
    int rem;
    w[0] = v.w0; w[1] = v.w1; w[2] = v.w2;
    lat = 0; pops = 0; first_pop = 0; last_pop = 0; stall_pops = 0; rem = -1;
    wr_ptr = rd_ptr;
    for (int i = 0; i < 3; i++) begin
      if (i < int'(v.n)) begin
        fifo_mem[wr_ptr % 16] = w[i];
        wr_ptr = wr_ptr + 1;
      end
    end
    start = 1'b1; n_terms = v.n; bias = v.b;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (in_pop) begin
        pops++;
        if (first_pop == 0) first_pop = cyc;
        last_pop = cyc;
        if (stall) stall_pops++;
      end
      if (out_valid) begin
        lat = cyc;
        break;
      end
      @(posedge clk); #1;
      if (rem > 0) begin
        rem--;
        if (rem == 0) stall = 1'b0;
      end
      if (rem < 0 && stall_len > 0 && pops == stall_after) begin
        stall = 1'b1;
        rem = stall_len;
      end
    end
    stall = 1'b0;
  endtask

  initial begin
    int lat, pops, fp, lp, sp, bad;
    vecs[0] = '{8'd3, 16'h0080, 32'h0100_0200, 32'h0080_0400, 32'hFF00_0100, 16'h0380, 5};
    vecs[1] = '{8'd2, 16'h0000, 32'h7F00_7F00, 32'h7F00_7F00, 32'h0, 16'h7FFF, 4};
    vecs[2] = '{8'd2, 16'h0000, 32'h8100_7F00, 32'h8100_7F00, 32'h0, neg_exp(16'h8000), 4};
    vecs[3] = '{8'd1, 16'h0000, 32'hFE00_0300, 32'h0, 32'h0, neg_exp(16'hFA00), 3};
    vecs[4] = '{8'd0, 16'h0180, 32'h0, 32'h0, 32'h0, 16'h0180, 2};
    vecs[5] = '{8'd1, 16'h0000, 32'h0001_FFFF, 32'h0, 32'h0, neg_exp(16'hFFFF), 3};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_pop", {31'd0, in_pop}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven jobs
    for (int k = 0; k < 6; k++) begin
      run(vecs[k], 0, 0, lat, pops, fp, lp, sp);
      chk($sformatf("v%0d_data", k), {16'd0, out_data}, {16'd0, vecs[k].exp_data});
      chk($sformatf("v%0d_latency", k), lat, vecs[k].exp_lat);
      chk($sformatf("v%0d_pops", k), pops, int'(vecs[k].n));
      if (vecs[k].n != 8'd0) chk($sformatf("v%0d_pop_span", k), lp - fp + 1, int'(vecs[k].n));
      chk($sformatf("v%0d_busy", k), {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("v%0d_valid_drop", k), {31'd0, out_valid}, 32'd0);
      chk($sformatf("v%0d_data_keep", k), {16'd0, out_data}, {16'd0, vecs[k].exp_data});
      @(posedge clk); #1;
    end

    // Empty stall of 4 cycles after the first pop
    run(vecs[0], 1, 4, lat, pops, fp, lp, sp);
    chk("stall_data", {16'd0, out_data}, 32'h0380);
    chk("stall_latency", lat, 9);
    chk("stall_pops_during", sp, 0);
    chk("stall_pops", pops, 3);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Backpressure: hold out_ready low, pulse start during the hold
    out_ready = 1'b0;
    run(vecs[0], 0, 0, lat, pops, fp, lp, sp);
    chk("bp_latency", lat, 5);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      start = (c % 2 == 0); n_terms = 8'd0; bias = 16'h7FFF;
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== 16'h0380 || busy !== 1'b1) bad++;
    end
    start = 1'b0;
    chk("bp_hold_bad_cycles", bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_no_late_start", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Reset mid-ACCUM after 1 of 3 pops
    wr_ptr = rd_ptr;
    fifo_mem[wr_ptr % 16] = vecs[0].w0; wr_ptr = wr_ptr + 1;
    fifo_mem[wr_ptr % 16] = vecs[0].w1; wr_ptr = wr_ptr + 1;
    fifo_mem[wr_ptr % 16] = vecs[0].w2; wr_ptr = wr_ptr + 1;
    start = 1'b1; n_terms = 8'd3; bias = 16'h0080;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_one_pop", wr_ptr - rd_ptr, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_pop_gated", {31'd0, in_pop}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_pop", {31'd0, in_pop}, 32'd0);
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_out_data", {16'd0, out_data}, 32'h0);
    chk("rst_mid_fifo_kept", wr_ptr - rd_ptr, 2);
    @(posedge clk); #1;
    run(vecs[0], 0, 0, lat, pops, fp, lp, sp);
    chk("rerun_data", {16'd0, out_data}, 32'h0380);
    chk("rerun_latency", lat, 5);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
